// File: rtl/fp_pkg.sv
// fp_pkg: shared binary32 type and constants for the fp_add_sub datapath
package fp_pkg;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;
  localparam int          FP_BIAS    = 127;
  localparam int          FP_EXP_MAX = 255;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [31:0] FP_POS_INF = 32'h7F800000;
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational 28-bit leading-zero count (28 when all zero)
module fp_lzc (
  input  logic [27:0] d,
  output logic [4:0]  cnt
);
  always_comb begin
    cnt = 5'd28;
    for (int i = 0; i < 28; i++) if (d[i]) cnt = 5'(27 - i);
  end
endmodule

// File: rtl/fp_add_sub.sv
// fp_add_sub: registered binary32 add/subtract, 1-cycle latency
// FP_ADD_SUB_RNE_EN selects round-to-nearest-even; otherwise results truncate toward zero
module fp_add_sub
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] opd1,
  input  logic [31:0] opd2,
  input  logic        op,
  output logic [31:0] res,
  output logic        exp_overflow_flag,
  output logic        exp_underflow_flag,
  output logic        nan_flag
);
  fp32_t             a, b, x, y;
  logic [30:0]       mag_a, mag_b;
  logic [23:0]       sig_x, sig_y, n_sig;
  logic [7:0]        diff, sh;
  logic [51:0]       wide;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic              inc;
  logic [24:0]       rnd;
  logic signed [9:0] e, er;
  logic              nan_a, nan_b, inf_a, inf_b, nan_c, inf_c, zero_c, of_c, uf_c;
  logic [31:0]       res_c;
  assign a = opd1;
  assign b = {opd2[31] ^ op, opd2[30:0]};
  assign mag_a = a.exp == 8'd0 ? 31'd0 : a[30:0];
  assign mag_b = b.exp == 8'd0 ? 31'd0 : b[30:0];
  assign {x, y} = mag_b > mag_a ? {b, a} : {a, b};
  assign sig_x = x.exp == 8'd0 ? 24'd0 : {1'b1, x.frac};
  assign sig_y = y.exp == 8'd0 ? 24'd0 : {1'b1, y.frac};
  assign diff = x.exp - y.exp;
  assign sh = diff > 8'd26 ? 8'd26 : diff;
  // Smaller significand plus guard/round lands in wide[51:26]; everything below folds into sticky
  assign wide = {sig_y, 28'd0} >> sh;
  assign sum = x.sign == y.sign ? {1'b0, sig_x, 3'd0} + {1'b0, wide[51:26], |wide[25:0]}
                                : {1'b0, sig_x, 3'd0} - {1'b0, wide[51:26], |wide[25:0]};
  fp_lzc u_lzc (.d(sum), .cnt(lz));
`ifdef FP_ADD_SUB_RNE_EN
  logic [2:0] grs;
  assign {n_sig, grs} = sum[27] ? {sum[27:2], |sum[1:0]} : 27'(sum << (lz - 5'd1));
  assign inc = grs[2] & (grs[1] | grs[0] | n_sig[0]);
`else
  assign n_sig = sum[27] ? sum[27:4] : 24'((sum << (lz - 5'd1)) >> 3);
  assign inc = 1'b0;
`endif
  assign e = sum[27] ? $signed({2'b0, x.exp}) + 10'sd1
                     : $signed({2'b0, x.exp}) - $signed({5'd0, lz}) + 10'sd1;
  assign rnd = {1'b0, n_sig} + {24'd0, inc};
  assign er = e + $signed({9'd0, rnd[24]});
  assign nan_a = a.exp == 8'(FP_EXP_MAX) && a.frac != 23'd0;
  assign nan_b = b.exp == 8'(FP_EXP_MAX) && b.frac != 23'd0;
  assign inf_a = a.exp == 8'(FP_EXP_MAX) && a.frac == 23'd0;
  assign inf_b = b.exp == 8'(FP_EXP_MAX) && b.frac == 23'd0;
  assign nan_c = nan_a | nan_b | (inf_a & inf_b & (a.sign ^ b.sign));
  assign inf_c = !nan_c && (inf_a | inf_b);
  assign zero_c = sum == 28'd0;
  assign of_c = !nan_c && !inf_c && !zero_c && er > $signed(10'(2 * FP_BIAS));
  assign uf_c = !nan_c && !inf_c && !zero_c && er < 10'sd1;
  assign res_c = nan_c  ? FP_QNAN
               : inf_c  ? FP_POS_INF | {inf_a ? a.sign : b.sign, 31'd0}
               : zero_c ? {x.sign & y.sign, 31'd0}
               : of_c   ? FP_POS_INF | {x.sign, 31'd0}
               : uf_c   ? {x.sign, 31'd0}
               : {x.sign, er[7:0], rnd[24] ? rnd[23:1] : rnd[22:0]};
  always_ff @(posedge clk)
    if (rst) {res, exp_overflow_flag, exp_underflow_flag, nan_flag} <= '0;
    else {res, exp_overflow_flag, exp_underflow_flag, nan_flag} <= {res_c, of_c, uf_c, nan_c};
endmodule

// File: tb/tb_fp_add_sub.sv
// tb_fp_add_sub: scoreboard bench for fp_add_sub against an exact-arithmetic reference model
module tb_fp_add_sub;
  logic        clk = 1'b0, rst = 1'b1, op = 1'b0;
  logic [31:0] opd1 = '0, opd2 = '0, res;
  logic        of, uf, nf;
  int          checks = 0, errors = 0;

  typedef struct {
    logic [34:0] e;
    string       nm;
  } item_t;
  item_t sb[$];

  fp_add_sub dut (
    .clk(clk), .rst(rst), .opd1(opd1), .opd2(opd2), .op(op),
    .res(res), .exp_overflow_flag(of), .exp_underflow_flag(uf), .nan_flag(nf)
  );

  always #5 clk = ~clk;

  // Exact sum in a wide integer (units of 2^-149), then one rounding step to binary32.
  function automatic logic [34:0] model(input logic [31:0] p, input logic [31:0] q, input logic o);
    logic sa, sb_, s, na, nb, ia, ib;
    int ea, eb, pos, ex, sh;
    logic [279:0] ma, mb, m, keep;
`ifdef FP_ADD_SUB_RNE_EN
    logic [279:0] rem, half;
`endif
    sa = p[31]; sb_ = q[31] ^ o;
    ea = int'(p[30:23]); eb = int'(q[30:23]);
    na = ea == 255 && p[22:0] != 0; nb = eb == 255 && q[22:0] != 0;
    ia = ea == 255 && p[22:0] == 0; ib = eb == 255 && q[22:0] == 0;
    if (na || nb || (ia && ib && sa != sb_)) return {32'h7FC00000, 3'b001};
    if (ia) return {sa, 8'hFF, 23'd0, 3'b000};
    if (ib) return {sb_, 8'hFF, 23'd0, 3'b000};
    ma = ea == 0 ? '0 : {256'd0, 1'b1, p[22:0]} << (ea - 1);
    mb = eb == 0 ? '0 : {256'd0, 1'b1, q[22:0]} << (eb - 1);
    if (sa == sb_) begin m = ma + mb; s = sa; end
    else if (ma >= mb) begin m = ma - mb; s = sa; end
    else begin m = mb - ma; s = sb_; end
    if (m == 0) return {(sa == sb_) ? sa : 1'b0, 34'd0};
    pos = 0;
    for (int i = 0; i < 280; i++) if (m[i]) pos = i;
    ex = pos - 22;
    if (pos >= 23) begin
      sh = pos - 23;
      keep = m >> sh;
`ifdef FP_ADD_SUB_RNE_EN
      rem = m & ((280'd1 << sh) - 1);
      half = sh > 0 ? 280'd1 << (sh - 1) : '0;
      if (sh > 0 && (rem > half || (rem == half && keep[0]))) keep = keep + 1;
`endif
      if (keep[24]) begin keep = keep >> 1; ex++; end
    end else keep = m << (23 - pos);
    if (ex > 254) return {s, 8'hFF, 23'd0, 3'b100};
    if (ex < 1) return {s, 31'd0, 3'b010};
    return {s, ex[7:0], keep[22:0], 3'b000};
  endfunction

  task automatic apply(input logic r, input logic [31:0] a, input logic [31:0] b,
                       input logic o, input logic [34:0] e, input string nm);
    @(negedge clk);
    rst = r; opd1 = a; opd2 = b; op = o;
    sb.push_back('{e, nm});
  endtask

  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        checks++;
        if ({res, of, uf, nf} !== it.e) begin
          errors++;
          $display("FAIL %s: got res=%h of/uf/nan=%b, expected res=%h of/uf/nan=%b",
                   it.nm, res, {of, uf, nf}, it.e[34:3], it.e[2:0]);
        end
      end
    end
  end

  initial begin
    apply(1, 32'h3F800000, 32'h40000000, 0, 35'd0, "reset");
    apply(0, 32'h3F800000, 32'h40000000, 0, {32'h40400000, 3'b000}, "one_plus_two");
    apply(0, 32'h3F800000, 32'h3F800000, 1, {32'h00000000, 3'b000}, "one_minus_one");
    apply(0, 32'h40400000, 32'h3F800000, 1, {32'h40000000, 3'b000}, "three_minus_one");
    apply(0, 32'h3F800000, 32'h33800000, 0, {32'h3F800000, 3'b000}, "half_ulp_tie");
    apply(0, 32'h3F800000, 32'h34000000, 0, {32'h3F800001, 3'b000}, "one_ulp");
`ifdef FP_ADD_SUB_RNE_EN
    apply(0, 32'h3F800000, 32'h33FFFFFF, 0, {32'h3F800001, 3'b000}, "above_half_ulp");
    apply(0, 32'h3F800000, 32'h30800000, 1, {32'h3F800000, 3'b000}, "one_minus_tiny");
`else
    apply(0, 32'h3F800000, 32'h33FFFFFF, 0, {32'h3F800000, 3'b000}, "above_half_ulp");
    apply(0, 32'h3F800000, 32'h30800000, 1, {32'h3F7FFFFF, 3'b000}, "one_minus_tiny");
`endif
    apply(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, {32'h7F800000, 3'b100}, "overflow");
    apply(0, 32'h00C00000, 32'h00800000, 1, {32'h00000000, 3'b010}, "underflow");
    apply(0, 32'h7F800000, 32'h7F800000, 1, {32'h7FC00000, 3'b001}, "inf_minus_inf");
    apply(0, 32'h7FC00001, 32'h3F800000, 0, {32'h7FC00000, 3'b001}, "nan_in");
    apply(0, 32'h00000000, 32'h00000000, 0, {32'h00000000, 3'b000}, "pz_plus_pz");
    apply(0, 32'h80000000, 32'h80000000, 0, {32'h80000000, 3'b000}, "nz_plus_nz");
    apply(0, 32'h80000000, 32'h00000000, 1, {32'h80000000, 3'b000}, "nz_minus_pz");
    apply(0, 32'h80000001, 32'h00000000, 0, {32'h00000000, 3'b000}, "subnorm_plus_pz");
    apply(0, 32'h00400000, 32'h3F800000, 0, {32'h3F800000, 3'b000}, "subnorm_plus_one");
    apply(0, 32'hFF800000, 32'h3F800000, 0, {32'hFF800000, 3'b000}, "neg_inf");
    apply(0, 32'h3F800000, 32'h7F800000, 1, {32'hFF800000, 3'b000}, "minus_inf");
    apply(0, 32'h7F800000, 32'h7F800000, 0, {32'h7F800000, 3'b000}, "inf_plus_inf");
    apply(0, 32'h3F800000, 32'hBF800000, 0, {32'h00000000, 3'b000}, "cancel_zero");
    apply(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 35'd0, "rst_held");
    apply(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, {32'h7F800000, 3'b100}, "rst_release");
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a, b;
      logic o;
      int k, eb;
      a = $urandom;
      o = 1'($urandom);
      a[30:23] = 8'($urandom_range(1, 254));
      eb = int'(a[30:23]) + int'($urandom_range(0, 60)) - 30;
      eb = eb < 1 ? 1 : eb > 254 ? 254 : eb;
      b = {1'($urandom), 8'(eb), 23'($urandom)};
      k = int'($urandom_range(0, 9));
      if (k == 0) b = a;
      else if (k == 1) b = a ^ 32'd1;
      else if (k == 2) begin
        a[30:23] = 8'($urandom_range(250, 254)); b[30:23] = 8'($urandom_range(250, 254));
      end else if (k == 3) begin
        a[30:23] = 8'($urandom_range(1, 3)); b[30:23] = 8'($urandom_range(1, 3));
      end else if (k == 4) begin
        a[30:23] = $urandom_range(0, 1) ? 8'hFF : 8'h00;
        if ($urandom_range(0, 1)) a[22:0] = '0;
      end else if (k == 5) b = $urandom;
      if ($urandom_range(0, 1)) {a, b} = {b, a};
      apply(0, a, b, o, model(a, b, o), "random");
    end
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never observed, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_add_sub.md
FP_ADD_SUB -- requirements
Module: fp_add_sub

Interface
- REQ-001: The block SHALL have no parameters; the format is fixed to IEEE-754 binary32 (1 sign, 8 exponent, 23 fraction bits).
- REQ-002: clk  input  1  the single clock; all state updates on the rising edge.
- REQ-003: rst  input  1  reset, synchronous and active-high.
- REQ-004: opd1  input  32  first operand, binary32.
- REQ-005: opd2  input  32  second operand, binary32.
- REQ-006: op  input  1  operation select: 0 = opd1 + opd2, 1 = opd1 - opd2.
- REQ-007: res  output  32  registered binary32 result.
- REQ-008: exp_overflow_flag  output  1  registered; result exponent exceeded 254.
- REQ-009: exp_underflow_flag  output  1  registered; nonzero result fell below the smallest normal, 2^-126.
- REQ-010: nan_flag  output  1  registered; result is NaN.

Function
- REQ-011: The datapath SHALL be combinational from inputs to the output registers. Outputs update on the clock edge after the inputs are applied, so latency is 1 cycle. A new operation is accepted every cycle. There is no handshake.
- REQ-012: Subtraction SHALL be computed as an add with the sign of opd2 inverted.
- REQ-013: Algorithm:
  - unpack, with the hidden bit set for exponent != 0;
  - swap so the larger magnitude is first;
  - right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits (sticky = OR of all bits shifted past the round bit; a difference >= 26 gives only sticky);
  - add or subtract the magnitudes;
  - normalize (1-bit right shift on carry-out, else left shift by the leading-zero count);
  - round, then renormalize if rounding carries out.
- REQ-014: Subnormal inputs (exponent 0) SHALL be treated as signed zero.
- REQ-015: Either operand NaN, or (+inf) + (-inf) after the op is applied, SHALL give res = 0x7FC00000 and nan_flag = 1.
- REQ-016: Any other infinite operand SHALL give that infinity, with its effective sign, and no flag set.
- REQ-017: Overflow: if the rounded exponent is > 254, res SHALL be ±inf (0x7F800000 | sign<<31) and exp_overflow_flag = 1.
- REQ-018: Underflow: if a nonzero rounded result has exponent < 1, res SHALL be signed zero and exp_underflow_flag = 1.
- REQ-019: An exact zero result from unlike-signed operands SHALL be +0. (+0) + (+0) SHALL give +0 and (-0) + (-0) SHALL give -0. No flags are set for zero results.
- REQ-020: At most one flag SHALL be asserted per result.

Reset
- REQ-021: While rst = 1 at a rising edge, res SHALL load 0x00000000 and all three flags SHALL load 0.
- REQ-022: Deasserting rst mid-stream SHALL give the result of the operands present at the first edge after deassertion. No stale or partial result is retained.

Configuration
- REQ-023: With macro FP_ADD_SUB_RNE_EN defined, rounding SHALL be round-to-nearest, ties-to-even, using guard, round and sticky.
- REQ-024: Without FP_ADD_SUB_RNE_EN, rounding SHALL be truncation toward zero: the guard, round and sticky bits are discarded. All other behaviour is identical.

Structure
- REQ-025: Shared package fp_pkg SHALL hold:
  - typedef fp32_t, a packed struct of sign, exp[7:0] and frac[22:0];
  - constants FP_BIAS = 127, FP_EXP_MAX = 255, FP_QNAN = 0x7FC00000, FP_POS_INF = 0x7F800000.
- REQ-026: One sub-module, fp_lzc, SHALL provide a combinational 28-bit leading-zero count used for normalization. No other sub-modules are used.

Verification (FP_ADD_SUB_RNE_EN defined unless noted; each check is one cycle after the inputs are applied)
- REQ-027: 0x3F800000 + 0x40000000, op=0 -> res 0x40400000, all flags 0.
- REQ-028: 0x3F800000 - 0x3F800000, op=1 -> res 0x00000000. Also 0x40400000 - 0x3F800000 -> 0x40000000.
- REQ-029: 0x3F800000 + 0x33800000 (a half-ulp tie) -> res 0x3F800000. 0x3F800000 + 0x34000000 -> 0x3F800001. Without the macro, 0x3F800000 + 0x33FFFFFF -> 0x3F800000.
- REQ-030: 0x7F7FFFFF + 0x7F7FFFFF -> res 0x7F800000, exp_overflow_flag 1.
- REQ-031: 0x00C00000 - 0x00800000 -> res 0x00000000, exp_underflow_flag 1.
- REQ-032: 0x7F800000 - 0x7F800000 -> res 0x7FC00000, nan_flag 1. 0x7FC00001 + 0x3F800000 -> 0x7FC00000, nan_flag 1. Asserting rst while inputs are held -> res 0 and flags 0 on the next edge.
